vliw_fetch_queue: RTL

- Fetch stage of the 6-slot VLIW core; sits directly upstream of bundle dispatch.
- Generates the sequential bundle PC and reads 192-bit bundles from synchronous instruction memory.
- Buffers fetched bundles in a small FIFO and presents them to dispatch over a valid/ready handshake.
- Supports redirect: flushes queued and in-flight bundles, then restarts fetch at a new PC.

---
 rtl/vliw_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/vliw_fetch_queue.sv | 96 +++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: slot geometry, slot indices and the packed bundle type.
// Used by fetch, dispatch and their benches.
package vliw_pkg;

    localparam int SLOT_W    = 32;
    localparam int NUM_SLOTS = 6;
    localparam int BUNDLE_W  = SLOT_W * NUM_SLOTS;

    localparam int SLOT_ADD = 0;
    localparam int SLOT_MUL = 1;
    localparam int SLOT_FPA = 2;
    localparam int SLOT_FPM = 3;
    localparam int SLOT_LU  = 4;
    localparam int SLOT_MEM = 5;

    // Slot k occupies bits [32k+31:32k] of the flattened bundle.
    typedef logic [NUM_SLOTS-1:0][SLOT_W-1:0] bundle_t;

    // Even parity over a slot instruction.
    function automatic logic slot_parity(input logic [SLOT_W-1:0] slot);
        return ^slot;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; the head entry is read straight from storage.
// Storage is cleared on reset so the head reads as zero until the first push.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop && (count_q != CNT_W'(0));
    assign push_ok_s = push && (count_q != CNT_W'(DEPTH));

    // Next-state for storage, pointers and count; flush discards everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/vliw_fetch_queue.sv
// Fetch stage: sequential bundle PC, synchronous imem reads with credit-based
// issue, and a bundle FIFO toward dispatch with redirect flush.
module vliw_fetch_queue #(
    parameter  int SLOT_W    = 32,
    parameter  int NUM_SLOTS = 6,
    parameter  int ADDR_W    = 8,
    parameter  int DEPTH     = 4,
    parameter  int RESET_PC  = 0,
    localparam int BUNDLE_W  = SLOT_W * NUM_SLOTS,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [BUNDLE_W-1:0] imem_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUNDLE_W-1:0] out_bundle,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [CNT_W-1:0]    occupancy
);

    localparam int ENTRY_W = BUNDLE_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pending_q, pending_d;
    logic [ADDR_W-1:0]  pending_pc_q, pending_pc_d;
    logic               pop_s;
    logic               push_s;
    logic               issue_s;
    logic [CNT_W:0]     credit_s;
    logic [ENTRY_W-1:0] head_s;

    assign pop_s  = out_valid && out_ready;
    assign push_s = pending_q && !redirect_valid;

    // Entries held or already promised to the FIFO after this cycle's pop.
    assign credit_s = {1'b0, occupancy} + (CNT_W+1)'(pending_q) - (CNT_W+1)'(pop_s);
    assign issue_s  = !rst && !redirect_valid && (credit_s < (CNT_W+1)'(DEPTH));

    // PC and outstanding-read tracking; a redirect drops any in-flight read.
    always_comb begin
        pc_d         = pc_q;
        pending_d    = issue_s;
        pending_pc_d = pending_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue_s) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
        if (issue_s) begin
            pending_pc_d = pc_q;
        end else begin
            pending_pc_d = pending_pc_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= ADDR_W'(RESET_PC);
            pending_q    <= 1'b0;
            pending_pc_q <= ADDR_W'(0);
        end else begin
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({imem_rdata, pending_pc_q}),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (occupancy),
        .head_data (head_s)
    );

    assign imem_en    = issue_s;
    assign imem_addr  = pc_q;
    assign out_valid  = (occupancy != CNT_W'(0));
    assign out_bundle = head_s[ENTRY_W-1:ADDR_W];
    assign out_pc     = head_s[ADDR_W-1:0];

endmodule
